// File: rtl/rvic_axil_initiator.sv
// Single-outstanding AXI-lite initiator for the rvic register port.
// Ports: clk/rst_n (sync, active-low); req_* tile request; rsp_* tile
// response; axi_aw/w/b/ar/r* AXI-lite master channels; w_/r_reqbuf_size
// size sidebands. Optional watchdog: define RVIC_AXIL_INIT_TIMEOUT_EN.
module rvic_axil_initiator #(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AddrWidth-1:0]   req_addr,
  input  logic [2:0]             req_size,
  input  logic [DataWidth-1:0]   req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DataWidth-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic [AddrWidth-1:0]   axi_awaddr,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [DataWidth-1:0]   axi_wdata,
  output logic [DataWidth/8-1:0] axi_wstrb,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  output logic [AddrWidth-1:0]   axi_araddr,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [DataWidth-1:0]   axi_rdata,
  input  logic [1:0]             axi_rresp,
  input  logic                   axi_rvalid,
  output logic                   axi_rready,
  input  logic [1:0]             axi_bresp,
  input  logic                   axi_bvalid,
  output logic                   axi_bready,
  output logic [2:0]             w_reqbuf_size,
  output logic [2:0]             r_reqbuf_size
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_RADDR, S_WRESP, S_RRESP, S_DONE
  } state_e;

  localparam int unsigned HalfW = DataWidth - 32;

  state_e state;
  logic   size64_q;
  logic   req_ok;
  logic   aw_ok;
  logic   w_ok;
  logic   to_hit;

  always_comb begin
    req_ok = 1'b0;
    unique case (1'b1)
      (req_size == 3'b011): req_ok = (req_addr[2:0] == 3'b000);
      (req_size == 3'b010): req_ok = (req_addr[1:0] == 2'b00);
      default:              req_ok = 1'b0;
    endcase
  end

  assign req_ready = rst_n && (state == S_IDLE);

  // A channel is finished once its valid has been dropped or is
  // handshaking now; AW and W may complete in either order.
  assign aw_ok = !axi_awvalid || axi_awready;
  assign w_ok  = !axi_wvalid  || axi_wready;

`ifdef RVIC_AXIL_INIT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] to_cnt;

  // Cleared while idle so it restarts on entry to WADDR/RADDR, and
  // keeps running across the response phase.
  always_ff @(posedge clk) begin
    if (!rst_n || state == S_IDLE) begin
      to_cnt <= '0;
    end else if (state != S_DONE &&
                 to_cnt < CntW'(TimeoutCycles)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (to_cnt >= CntW'(TimeoutCycles - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      size64_q      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      axi_awaddr    <= '0;
      axi_awvalid   <= 1'b0;
      axi_wdata     <= '0;
      axi_wstrb     <= '0;
      axi_wvalid    <= 1'b0;
      axi_araddr    <= '0;
      axi_arvalid   <= 1'b0;
      axi_rready    <= 1'b0;
      axi_bready    <= 1'b0;
      w_reqbuf_size <= '0;
      r_reqbuf_size <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            size64_q <= req_size[0];
            if (!req_ok) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= S_DONE;
            end else if (req_write) begin
              axi_awaddr    <= req_addr;
              axi_wdata     <= req_size[0] ? req_wdata :
                               {{HalfW{1'b0}}, req_wdata[31:0]};
              axi_wstrb     <= req_size[0] ? '1 :
                               (DataWidth/8)'(4'hF);
              w_reqbuf_size <= req_size;
              axi_awvalid   <= 1'b1;
              axi_wvalid    <= 1'b1;
              state         <= S_WADDR;
            end else begin
              axi_araddr    <= req_addr;
              r_reqbuf_size <= req_size;
              axi_arvalid   <= 1'b1;
              state         <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          if (aw_ok && w_ok) begin
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b1;
            state       <= S_WRESP;
          end else if (to_hit) begin
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_rdata   <= '0;
            state       <= S_DONE;
          end else begin
            if (axi_awready) axi_awvalid <= 1'b0;
            if (axi_wready)  axi_wvalid  <= 1'b0;
          end
        end
        S_RADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_RRESP;
          end else if (to_hit) begin
            axi_arvalid <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_rdata   <= '0;
            state       <= S_DONE;
          end
        end
        S_WRESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= axi_bresp[1];
            rsp_rdata  <= '0;
            state      <= S_DONE;
          end else if (to_hit) begin
            axi_bready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rdata  <= '0;
            state      <= S_DONE;
          end
        end
        S_RRESP: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= axi_rresp[1];
            if (axi_rresp[1]) begin
              rsp_rdata <= '0;
            end else begin
              rsp_rdata <= size64_q ? axi_rdata :
                           {{HalfW{1'b0}}, axi_rdata[31:0]};
            end
            state <= S_DONE;
          end else if (to_hit) begin
            axi_rready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rdata  <= '0;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvic_axil_initiator.sv
// Bench for rvic_axil_initiator: directed requests against a delay-
// configurable AXI-lite slave, with a transaction-level model checker.
module tb_rvic_axil_initiator;

  localparam int TO = 16;
`ifdef RVIC_AXIL_INIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic [63:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [7:0]  axi_wstrb;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_rresp, axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [2:0]  w_reqbuf_size, r_reqbuf_size;

  rvic_axil_initiator #(
    .AddrWidth(64), .DataWidth(64), .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .w_reqbuf_size(w_reqbuf_size), .r_reqbuf_size(r_reqbuf_size)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // slave configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic        ar_never = 1'b0;
  logic [1:0]  bresp_c = 2'b00, rresp_c = 2'b00;
  logic [63:0] rdata_c = '0;
  int          awc = 0, wc = 0, arc = 0, bc = 0, rc = 0;

  initial begin
    axi_awready = 0; axi_wready = 0; axi_arready = 0;
    axi_bvalid = 0; axi_rvalid = 0;
    axi_bresp = 0; axi_rresp = 0; axi_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!axi_awvalid) awc = 0;
      axi_awready = axi_awvalid && (awc >= aw_dly);
      if (axi_awvalid) awc++;
      if (!axi_wvalid) wc = 0;
      axi_wready = axi_wvalid && (wc >= w_dly);
      if (axi_wvalid) wc++;
      if (!axi_arvalid) arc = 0;
      axi_arready = axi_arvalid && !ar_never && (arc >= ar_dly);
      if (axi_arvalid) arc++;
      if (!axi_bready) bc = 0;
      axi_bvalid = axi_bready && (bc >= b_dly);
      if (axi_bready) bc++;
      if (!axi_rready) rc = 0;
      axi_rvalid = axi_rready && (rc >= r_dly);
      if (axi_rready) rc++;
      axi_bresp = bresp_c;
      axi_rresp = rresp_c;
      axi_rdata = rdata_c;
    end
  end

  // transaction-level model state
  logic        busy = 0, cur_wr = 0, cur_legal = 0, got_rsp = 0;
  logic [63:0] cur_addr = '0, cur_wdata = '0;
  logic [2:0]  cur_size = '0;
  logic        aw_done = 0, w_done = 0, ar_done = 0;
  int          fl = 0, cyc = 0;
  logic [64:0] expq[$];
  logic        rst_pend = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, bhs_cnt = 0;
  logic [7:0]  last_wstrb = '0;
  logic [2:0]  last_wsize = '0, last_rsize = '0;

  function automatic logic legal(input logic [63:0] a,
                                 input logic [2:0] s);
    return (s == 3 && a % 8 == 0) || (s == 2 && a % 4 == 0);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_pend) begin
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_awaddr", axi_awaddr, 0);
        chk("rst_wdata", axi_wdata, 0);
        chk("rst_araddr", axi_araddr, 0);
        if (!rst_n) chk("rst_req_ready", req_ready, 0);
        busy = 0;
        got_rsp = 0;
        expq.delete();
      end
      rst_pend = !rst_n;
      if (rst_n) begin
        chk("req_ready", req_ready, !busy);
        if (!busy || !cur_legal || got_rsp) begin
          chk("idle_awvalid", axi_awvalid, 0);
          chk("idle_wvalid", axi_wvalid, 0);
          chk("idle_arvalid", axi_arvalid, 0);
          chk("idle_bready", axi_bready, 0);
          chk("idle_rready", axi_rready, 0);
        end else begin
          chk("awvalid", axi_awvalid, cur_wr && !aw_done);
          chk("wvalid", axi_wvalid, cur_wr && !w_done);
          chk("arvalid", axi_arvalid, !cur_wr && !ar_done);
          chk("bready", axi_bready, cur_wr && aw_done && w_done);
          chk("rready", axi_rready, !cur_wr && ar_done);
          if (axi_awvalid) chk("awaddr", axi_awaddr, cur_addr);
          if (axi_wvalid) begin
            chk("wstrb", axi_wstrb, cur_size == 3 ? 8'hFF : 8'h0F);
            chk("wsize", w_reqbuf_size, cur_size);
            if (cur_size == 3) chk("wdata", axi_wdata, cur_wdata);
            else chk("wdata32", axi_wdata[31:0], cur_wdata[31:0]);
          end
          if (axi_arvalid) begin
            chk("araddr", axi_araddr, cur_addr);
            chk("rsize", r_reqbuf_size, cur_size);
          end
        end
        chk("rsp_valid", rsp_valid, expq.size() != 0);
        if (rsp_valid && expq.size() != 0) begin
          chk("rsp_err", rsp_err, expq[0][64]);
          chk("rsp_rdata", rsp_rdata, expq[0][63:0]);
        end
        // events committed at the coming clock edge
        if (busy && cur_legal && !got_rsp) begin
          fl++;
          if (axi_awvalid && axi_awready) begin
            aw_done = 1; aw_hs_cyc = cyc;
          end
          if (axi_wvalid && axi_wready) begin
            w_done = 1; w_hs_cyc = cyc;
            last_wstrb = axi_wstrb; last_wsize = w_reqbuf_size;
          end
          if (axi_arvalid && axi_arready) begin
            ar_done = 1; last_rsize = r_reqbuf_size;
          end
          if (axi_bvalid && axi_bready) begin
            bhs_cnt++;
            expq.push_back({axi_bresp[1], 64'h0});
            got_rsp = 1;
          end else if (axi_rvalid && axi_rready) begin
            if (axi_rresp[1]) expq.push_back({1'b1, 64'h0});
            else if (cur_size == 2)
              expq.push_back({1'b0, 32'h0, axi_rdata[31:0]});
            else expq.push_back({1'b0, axi_rdata});
            got_rsp = 1;
          end else if (TO_EN && fl >= TO) begin
            expq.push_back({1'b1, 64'h0});
            got_rsp = 1;
          end
        end
        if (rsp_valid && rsp_ready && expq.size() != 0) begin
          void'(expq.pop_front());
          busy = 0;
        end
        if (req_valid && req_ready) begin
          busy = 1; cur_wr = req_write; cur_addr = req_addr;
          cur_size = req_size; cur_wdata = req_wdata;
          cur_legal = legal(req_addr, req_size);
          aw_done = 0; w_done = 0; ar_done = 0; fl = 0; got_rsp = 0;
          if (!cur_legal) begin
            expq.push_back({1'b1, 64'h0});
            got_rsp = 1;
          end
        end
      end
    end
  end

  task automatic txn(input logic wr, input logic [63:0] a,
                     input logic [2:0] sz, input logic [63:0] wd,
                     input int hold, output logic [63:0] rd,
                     output logic er, output int lat);
    int n;
    @(posedge clk); #1;
    req_valid = 1; req_write = wr; req_addr = a;
    req_size = sz; req_wdata = wd; rsp_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!rsp_valid && lat < 100);
    chk("rsp_seen", rsp_valid, 1);
    rd = rsp_rdata;
    er = rsp_err;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_req_ready", req_ready, 0);
        chk("hold_rdata", rsp_rdata, rd);
      end
      @(posedge clk); #1;
      rsp_ready = 1;
    end
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat, b0;
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = '0;
    req_size = '0; req_wdata = '0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t0_req_ready_after_rst", req_ready, 1);

    // 64-bit write, all channels ready
    txn(1, 64'hE200000008, 3'd3, 64'h1122334455667788, 0, rd, er, lat);
    chk("t1_latency", lat, 3);
    chk("t1_err", er, 0);
    chk("t1_rdata", rd, 0);
    chk("t1_wstrb", last_wstrb, 8'hFF);
    chk("t1_wsize", last_wsize, 3);
    chk("t1_aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);

    // 32-bit read, zero-extended
    rdata_c = 64'hDEADBEEFCAFEF00D;
    txn(0, 64'hE200200004, 3'd2, '0, 0, rd, er, lat);
    chk("t2_rdata", rd, 64'h00000000CAFEF00D);
    chk("t2_err", er, 0);
    chk("t2_rsize", last_rsize, 2);

    // W lags AW by two cycles
    w_dly = 2;
    b0 = bhs_cnt;
    txn(1, 64'hE200000010, 3'd3, 64'h0123456789ABCDEF, 0, rd, er, lat);
    chk("t3_w_after_aw", w_hs_cyc - aw_hs_cyc, 2);
    chk("t3_one_b", bhs_cnt - b0, 1);
    chk("t3_err", er, 0);
    w_dly = 0;

    // misaligned 64-bit read and bad size
    txn(0, 64'hE200000004, 3'd3, '0, 0, rd, er, lat);
    chk("t4_err", er, 1);
    chk("t4_latency", lat, 1);
    chk("t4_rdata", rd, 0);
    txn(1, 64'hE200000000, 3'd1, 64'h5, 0, rd, er, lat);
    chk("t4_badsize_err", er, 1);

    // SLVERR read and DECERR write
    rresp_c = 2'b10;
    txn(0, 64'hE200000018, 3'd3, '0, 0, rd, er, lat);
    chk("t5_rerr", er, 1);
    chk("t5_rdata", rd, 0);
    rresp_c = 2'b00;
    bresp_c = 2'b11;
    txn(1, 64'hE200000020, 3'd3, 64'h77, 0, rd, er, lat);
    chk("t5_berr", er, 1);
    bresp_c = 2'b00;

    // 32-bit write with response held off, slow slave
    aw_dly = 1; b_dly = 2;
    txn(1, 64'hE20000000C, 3'd2, 64'hAABBCCDD11223344, 5, rd, er, lat);
    chk("t6_err", er, 0);
    chk("t6_wstrb", last_wstrb, 8'h0F);
    chk("t6_wsize", last_wsize, 2);
    aw_dly = 0;

    // reset while waiting for B
    b_dly = 20;
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_addr = 64'hE200000028;
    req_size = 3'd3; req_wdata = 64'h99; rsp_ready = 1;
    @(negedge clk);
    chk("t7_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t7_in_wresp", axi_bready, 1);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t7_no_rsp", rsp_valid, 0);
      chk("t7_req_ready", req_ready, 1);
    end
    rsp_ready = 0;
    b_dly = 0;

    txn(0, 64'hE200000030, 3'd3, '0, 0, rd, er, lat);
    chk("t8_post_rst_rdata", rd, 64'hDEADBEEFCAFEF00D);

`ifdef RVIC_AXIL_INIT_TIMEOUT_EN
    ar_never = 1;
    txn(0, 64'hE200000038, 3'd3, '0, 0, rd, er, lat);
    chk("t9_to_err", er, 1);
    chk("t9_to_rdata", rd, 0);
    chk("t9_to_latency", lat, TO + 1);
    chk("t9_arvalid", axi_arvalid, 0);
    ar_never = 0;
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/rvic_axil_initiator.md
Name: rvic_axil_initiator

Overview:
- Single-outstanding AXI-lite initiator that drives the interrupt-controller register port (PLIC/CLINT AXI-lite slave side, including the non-standard size sidebands) from a simple tile-side request/response interface.
- Accepts 32-bit and 64-bit register reads and writes, issues the matching AXI-lite transaction and returns read data or an error flag.
- Sits between the tile's MMIO path and the rvic wrapper.

Parameters:
- AddrWidth, 64, request and AXI address width.
- DataWidth, 64, AXI data width; only 64 is supported.
- TimeoutCycles, 1024, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  64  byte address
- req_size  in  3  3'b010 = 32-bit, 3'b011 = 64-bit
- req_wdata  in  64  write data; 32-bit writes use [31:0]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  64  read data; 32-bit reads zero-extended; 0 for writes and errors
- rsp_err  out  1  error response
- axi_awaddr / axi_awvalid / axi_awready  out/out/in  64/1/1  AW channel
- axi_wdata / axi_wstrb / axi_wvalid / axi_wready  out/out/out/in  64/8/1/1  W channel
- axi_araddr / axi_arvalid / axi_arready  out/out/in  64/1/1  AR channel
- axi_rdata / axi_rresp / axi_rvalid / axi_rready  in/in/in/out  64/2/1/1  R channel
- axi_bresp / axi_bvalid / axi_bready  in/in/out  2/1/1  B channel
- w_reqbuf_size  out  3  write size sideband, stable while AW is pending
- r_reqbuf_size  out  3  read size sideband, stable while AR is pending

Behaviour:
- States: IDLE, WADDR, RADDR, WRESP, RRESP, DONE. State, the request capture registers and all AXI-side outputs are registered.
- Reset (rst_n low at a clk edge) forces IDLE and clears every valid, ready and data output to 0. This applies mid-transaction: the in-flight transfer is abandoned with no response.
- req_ready = (state == IDLE) and not in reset. On the first cycle after reset release it is 1.
- IDLE, on acceptance:
  - If req_size is not 2 or 3, or the address is misaligned (64-bit: addr[2:0] != 0; 32-bit: addr[1:0] != 0), go to DONE with rsp_err=1 and no bus activity.
  - Write: go to WADDR.
  - Read: go to RADDR.
- WADDR:
  - awvalid and wvalid both rise in the cycle after acceptance.
  - wstrb = 8'hFF for 64-bit, 8'h0F for 32-bit. w_reqbuf_size = req_size.
  - AW and W are tracked independently; each valid drops after its own handshake.
  - Go to WRESP when both handshakes are done, whether same-cycle or in either order.
- RADDR: arvalid rises the cycle after acceptance; go to RRESP on arready.
- WRESP / RRESP:
  - bready or rready is asserted unconditionally on entry. It must not depend on bvalid/rvalid, because the slave's valid depends combinationally on ready.
  - On handshake, capture data and go to DONE.
  - rsp_err = resp[1] (SLVERR/DECERR). rsp_rdata = rdata for 64-bit, {32'h0, rdata[31:0]} for 32-bit.
- DONE: rsp_valid=1, outputs held stable until rsp_ready, then IDLE. The earliest new acceptance is the cycle after rsp handshake.
- Minimum latency: request accept N, AW/W valid N+1, B handshake N+2 (slave ready), rsp_valid N+3.
- Payload signals (addr, data, strb, size sidebands) hold their values while the corresponding valid is high. Unaccepted valids are never withdrawn.

Optional Feature:
- Macro: RVIC_AXIL_INIT_TIMEOUT_EN.
- Enabled: a counter of width $clog2(TimeoutCycles+1) clears on entry to WADDR/RADDR and counts every cycle in WADDR, RADDR, WRESP and RRESP.
  - On reaching TimeoutCycles: drop all AXI valids and readies, go to DONE with rsp_err=1 and rsp_rdata=0.
  - A handshake in the same cycle as the limit wins over the timeout.
- Disabled: no counter; the block waits indefinitely.

Test Plan:
- 64-bit write addr 0xE200000008, data 0x1122334455667788, slave ready -> aw/w same cycle, wstrb 0xFF, w_reqbuf_size=3, bresp 0 -> rsp_valid, rsp_err=0, rsp_rdata=0, total 3 cycles.
- 32-bit read addr 0xE200200004, rdata 0xDEADBEEFCAFEF00D -> r_reqbuf_size=2, rsp_rdata=0x00000000CAFEF00D.
- awready 2 cycles before wready -> awvalid drops first, wvalid held with unchanged data, single bready handshake, one response.
- 64-bit read at addr 0xE200000004 -> no AXI valid ever asserted, rsp_err=1 next cycle. Read with rresp=2'b10 -> rsp_err=1.
- rsp_ready low 5 cycles -> rsp fields stable, req_ready=0; reset asserted in WRESP -> all outputs 0, IDLE, no rsp.
- With RVIC_AXIL_INIT_TIMEOUT_EN, TimeoutCycles=16, arready never high -> rsp_err=1 after 16 cycles and arvalid cleared.
